// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the 48MHz reference clock: holds the PLL in reset,
// waits for lock with timeout and bounded retries, qualifies lock, recovers on loss.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4800,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       relock_i,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       sample_rst_o,
  output logic       ready_o,
  output logic       error_o,
  output logic       lock_lost_o,
  output logic [1:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int unsigned RW = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             lock_lost_d;
  logic             lock_meta, lock_s;
  logic             pll_rst_d, sample_rst_d, ready_d, error_d;

  // LOCKED is asynchronous to clk_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked_i;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      lock_lost_o  <= 1'b0;
      pll_rst_o    <= 1'b1;
      sample_rst_o <= 1'b1;
      ready_o      <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lock_lost_o  <= lock_lost_d;
      pll_rst_o    <= pll_rst_d;
      sample_rst_o <= sample_rst_d;
      ready_o      <= ready_d;
      error_o      <= error_d;
    end
  end

  // Counter defaults to zero, so it clears on every state change and idles at zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_o;
    if (!enable_i) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RESET;
        S_RESET: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAULT;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAULT;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET;
            end
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d     = S_RESET;
            lock_lost_d = 1'b1;
          end else if (relock_i) begin
            state_d = S_RESET;
          end
        end
        S_FAULT: begin
          if (relock_i) begin
            state_d = S_RESET;
            retry_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pll_rst_d    = 1'b1;
    sample_rst_d = 1'b1;
    ready_d      = 1'b0;
    error_d      = 1'b0;
    case (state_d)
      S_WAIT_LOCK,
      S_STABLE: pll_rst_d = 1'b0;
      S_RUN: begin
        pll_rst_d    = 1'b0;
        sample_rst_d = 1'b0;
        ready_d      = 1'b1;
      end
      S_FAULT: error_d = 1'b1;
      default: ;
    endcase
  end

  assign retry_cnt_o = retry_q[1:0];
  assign state_o     = state_q;

  ready_invariant: assert property (@(posedge clk_i) ready_o |-> (!sample_rst_o && !pll_rst_o));

endmodule
